// File: rtl/facto_seq.sv
// facto_seq: bus-master sequencer in front of the factorial core.
// Accepts one operand at a time, programs the core over its slave register
// port (clear, interrupt enable, operand, start), waits for completion, reads
// RESULT_H/RESULT_L and presents the 128-bit result on an output stream.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_operand      operand stream (64-bit)
//   out_valid/out_ready               result stream handshake
//   out_result_h/out_result_l         result bits 127:64 / 63:0
//   out_timeout                       job aborted, results forced to zero
//   m_sel/m_wr/m_addr/m_dout/m_din    core slave register port
//   interrupt                         core done interrupt
//   busy                              high whenever not idle
//
// Build option: define FACTO_SEQ_POLL_EN to replace interrupt-driven completion
// with periodic polling of OP_DONE every POLL_INTERVAL wait cycles.
module facto_seq #(
  parameter logic [15:0] BASE_ADDR     = 16'h7000,
  parameter int unsigned TIMEOUT       = 65535,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_operand,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result_h,
  output logic [63:0] out_result_l,
  output logic        out_timeout,
  output logic        m_sel,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din,
  input  logic        interrupt,
  output logic        busy
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 32;

  localparam logic [AW-1:0] OFF_START    = AW'(16'h00);
  localparam logic [AW-1:0] OFF_CLEAR    = AW'(16'h08);
  localparam logic [AW-1:0] OFF_DONE     = AW'(16'h10);
  localparam logic [AW-1:0] OFF_INTR_EN  = AW'(16'h18);
  localparam logic [AW-1:0] OFF_OPERAND  = AW'(16'h20);
  localparam logic [AW-1:0] OFF_RESULT_H = AW'(16'h28);
  localparam logic [AW-1:0] OFF_RESULT_L = AW'(16'h30);

  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  // Reject configurations that would make the wait or poll period meaningless.
  if (TIMEOUT < 1 || POLL_INTERVAL < 1) begin : g_param_check
    $error("facto_seq: TIMEOUT and POLL_INTERVAL must be >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_SET, S_CLR_REL, S_INTR, S_OPND, S_START,
    S_WAIT, S_RD_H, S_RD_L, S_OUT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_operand;
  logic [CW-1:0] r_wait_cnt;
  logic [DW-1:0] r_res_h;
  logic [DW-1:0] r_res_l;
  logic          r_timeout;
  logic          w_done;
  logic          w_wait_last;

`ifdef FACTO_SEQ_POLL_EN
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_INTERVAL - 1);
  localparam logic [DW-1:0] INTR_EN_VAL = DW'(0);
  logic [CW-1:0] r_poll_cnt;
  logic          w_poll;

  // Completion is discovered by a read of OP_DONE on poll cycles only.
  assign w_poll = (r_state == S_WAIT) && (r_poll_cnt == POLL_LAST);
  assign w_done = w_poll && m_din[0];

  always_ff @(posedge clk) begin
    if (!reset_n || r_state != S_WAIT || r_poll_cnt == POLL_LAST) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + CW'(1);
    end
  end
`else
  localparam logic [DW-1:0] INTR_EN_VAL = DW'(1);
  assign w_done = interrupt;
`endif

  assign w_wait_last = (r_wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; completion wins over timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (in_valid) w_next = S_CLR_SET;
      S_CLR_SET: w_next = S_CLR_REL;
      S_CLR_REL: w_next = S_INTR;
      S_INTR:    w_next = S_OPND;
      S_OPND:    w_next = S_START;
      S_START:   w_next = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          w_next = S_RD_H;
        end else if (w_wait_last) begin
          w_next = S_OUT;
        end
      end
      S_RD_H:    w_next = S_RD_L;
      S_RD_L:    w_next = S_OUT;
      S_OUT:     if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output decode: bus cycle and handshake flags from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    m_sel     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    unique case (r_state)
      S_IDLE:    in_ready = reset_n;
      S_CLR_SET: begin m_sel = 1'b1; m_wr = 1'b1; m_addr = BASE_ADDR + OFF_CLEAR;   m_dout = DW'(1); end
      S_CLR_REL: begin m_sel = 1'b1; m_wr = 1'b1; m_addr = BASE_ADDR + OFF_CLEAR;   m_dout = DW'(0); end
      S_INTR:    begin m_sel = 1'b1; m_wr = 1'b1; m_addr = BASE_ADDR + OFF_INTR_EN; m_dout = INTR_EN_VAL; end
      S_OPND:    begin m_sel = 1'b1; m_wr = 1'b1; m_addr = BASE_ADDR + OFF_OPERAND; m_dout = r_operand; end
      S_START:   begin m_sel = 1'b1; m_wr = 1'b1; m_addr = BASE_ADDR + OFF_START;   m_dout = DW'(1); end
      S_WAIT: begin
`ifdef FACTO_SEQ_POLL_EN
        if (w_poll) begin
          m_sel  = 1'b1;
          m_addr = BASE_ADDR + OFF_DONE;
        end
`endif
      end
      S_RD_H:    begin m_sel = 1'b1; m_addr = BASE_ADDR + OFF_RESULT_H; end
      S_RD_L:    begin m_sel = 1'b1; m_addr = BASE_ADDR + OFF_RESULT_L; end
      S_OUT:     out_valid = 1'b1;
      default:   ;
    endcase
  end

  // Operand latch, wait counter and result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_operand  <= '0;
      r_wait_cnt <= '0;
      r_res_h    <= '0;
      r_res_l    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_operand <= in_operand;
            r_timeout <= 1'b0;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
          if (!w_done && w_wait_last) begin
            r_timeout <= 1'b1;
            r_res_h   <= '0;
            r_res_l   <= '0;
          end
        end
        S_RD_H:  r_res_h <= m_din;
        S_RD_L:  r_res_l <= m_din;
        default: ;
      endcase
    end
  end

  assign out_result_h = r_res_h;
  assign out_result_l = r_res_l;
  assign out_timeout  = r_timeout;

  // OP_DONE offset is only addressed in the polling build.
  logic w_unused_off;
  assign w_unused_off = ^OFF_DONE;

endmodule

// File: tb/tb_facto_seq.sv
// Self-checking bench for facto_seq with a behavioural factorial core attached.
module tb_facto_seq;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_operand;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result_h;
  logic [63:0] out_result_l;
  logic        out_timeout;
  logic        m_sel;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din;
  logic        interrupt;
  logic        busy;

  facto_seq #(.BASE_ADDR(16'h7000), .TIMEOUT(TO), .POLL_INTERVAL(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_operand(in_operand),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result_h(out_result_h), .out_result_l(out_result_l), .out_timeout(out_timeout),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .interrupt(interrupt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rst_hit = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (longint unsigned i = 2; i <= 64'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  // ---------------- behavioural factorial core ----------------
  int           core_delay = 5;
  bit           core_dead  = 1'b0;
  logic [127:0] c_res  = '0;
  logic         c_done = 1'b0;
  logic         c_ien  = 1'b0;
  logic         c_pend = 1'b0;
  logic [63:0]  c_opnd = '0;
  int           c_cnt  = 0;

  always @(posedge clk) begin
    if (c_pend) begin
      if (c_cnt <= 1) begin
        c_pend <= 1'b0;
        c_done <= 1'b1;
        c_res  <= fact(c_opnd);
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
    if (m_sel && m_wr) begin
      case (m_addr)
        16'h7008: if (m_dout[0]) begin c_done <= 1'b0; c_res <= '0; c_pend <= 1'b0; c_ien <= 1'b0; end
        16'h7018: c_ien <= m_dout[0];
        16'h7020: c_opnd <= m_dout;
        16'h7000: if (m_dout[0]) begin c_pend <= 1'b1; c_cnt <= core_delay; end
        default: ;
      endcase
    end
  end

  assign interrupt = c_done & c_ien & ~core_dead;

  always_comb begin
    m_din = 64'd0;
    if (m_sel && !m_wr) begin
      case (m_addr)
        16'h7028: m_din = c_res[127:64];
        16'h7030: m_din = c_res[63:0];
        16'h7010: m_din = {63'd0, c_done};
        default:  m_din = 64'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_hit <= ~reset_n;
  end

  // ---------------- reference model and compare ----------------
  bit           m_active = 1'b0;
  int           m_acc;
  int           m_irq;
  logic [63:0]  m_op;
  int           rel;
  logic         exp_to;
  logic [127:0] exp_res;
  logic [63:0]  last_h, last_l;
  logic         last_to;
  logic [63:0]  exp_wd;

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_m_sel"}, m_sel, 0);
    chk({tag, "_m_wr"}, m_wr, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_dout"}, m_dout, 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n && !rst_hit) begin
      m_active = 1'b0;
    end else begin
      if (rst_hit) begin
        m_active = 1'b0;
        chk("rst_out_timeout", out_timeout, 0);
        chk("rst_res_h", out_result_h, 0);
        chk("rst_res_l", out_result_l, 0);
      end
      if (!m_active) begin
        chk("idle_in_ready", in_ready, reset_n);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        chk_bus_idle("idle");
        if (reset_n && in_valid) begin
          m_active = 1'b1;
          m_acc    = cyc;
          m_op     = in_operand;
          m_irq    = -1;
        end
      end else begin
        rel = cyc - m_acc;
        chk("job_busy", busy, 1);
        chk("job_in_ready", in_ready, 0);
        if (rel <= 5) begin
          chk("wr_sel", m_sel, 1);
          chk("wr_wr", m_wr, 1);
          case (rel)
            1: begin chk("wr_addr1", m_addr, 16'h7008); exp_wd = 64'd1; end
            2: begin chk("wr_addr2", m_addr, 16'h7008); exp_wd = 64'd0; end
            3: begin chk("wr_addr3", m_addr, 16'h7018); exp_wd = 64'd1; end
            4: begin chk("wr_addr4", m_addr, 16'h7020); exp_wd = m_op; end
            default: begin chk("wr_addr5", m_addr, 16'h7000); exp_wd = 64'd1; end
          endcase
          chk("wr_data", m_dout, exp_wd);
          chk("wr_out_valid", out_valid, 0);
        end else if (m_irq < 0 && rel <= 5 + TO) begin
          chk_bus_idle("wait");
          chk("wait_out_valid", out_valid, 0);
          if (interrupt) m_irq = cyc;
        end else if (m_irq >= 0 && cyc == m_irq + 1) begin
          chk("rdh_sel", m_sel, 1);
          chk("rdh_wr", m_wr, 0);
          chk("rdh_addr", m_addr, 16'h7028);
          chk("rdh_out_valid", out_valid, 0);
        end else if (m_irq >= 0 && cyc == m_irq + 2) begin
          chk("rdl_sel", m_sel, 1);
          chk("rdl_wr", m_wr, 0);
          chk("rdl_addr", m_addr, 16'h7030);
          chk("rdl_out_valid", out_valid, 0);
        end else begin
          exp_to  = (m_irq < 0);
          exp_res = exp_to ? 128'd0 : fact(m_op);
          chk("out_valid", out_valid, 1);
          chk("out_timeout", out_timeout, exp_to);
          chk("out_res_h", out_result_h, exp_res[127:64]);
          chk("out_res_l", out_result_l, exp_res[63:0]);
          chk_bus_idle("out");
          if (out_ready) begin
            last_h   = out_result_h;
            last_l   = out_result_l;
            last_to  = out_timeout;
            m_active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [63:0] op);
    bit hs;
    hs = 1'b0;
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_operand = op;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
    end
    chk("send_accepted", hs, 1);
    in_valid   = 1'b0;
    in_operand = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("job_finished", ok, 1);
  endtask

  initial begin
    bit seen;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_operand = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    core_delay = 5;
    send(64'd5);
    wait_idle();
    chk("lit5_h", last_h, 0);
    chk("lit5_l", last_l, 120);

    send(64'd0);
    wait_idle();
    chk("lit0_l", last_l, 1);
    chk("lit0_to", last_to, 0);
    send(64'd1);
    wait_idle();
    chk("lit1_l", last_l, 1);
    chk("lit1_to", last_to, 0);

    send(64'd3);
    send(64'd4);
    wait_idle();
    chk("lit4_l", last_l, 24);

    rdy_mode = 2;
    send(64'd10);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("hold_out_valid_seen", seen, 1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    wait_idle();
    chk("lit10_l", last_l, 3628800);

    core_dead = 1'b1;
    send(64'd7);
    wait_idle();
    chk("lit_to_flag", last_to, 1);
    chk("lit_to_l", last_l, 0);
    core_dead = 1'b0;

    core_delay = 60;
    send(64'd9);
    repeat (12) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    core_delay = 4;
    send(64'd6);
    wait_idle();
    chk("lit6_l", last_l, 720);

    rdy_mode = 1;
    for (int j = 0; j < 40; j++) begin
      core_delay = $urandom_range(1, 110);
      send(64'($urandom_range(0, 34)));
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
